student_tlul_mem: RTL and testbench



---
 rtl/student_tlul_mem_pkg.sv | 23 ++
 rtl/tlul_pkg.sv | 48 ++++
 rtl/prim_fifo_sync.sv | 55 +++++
 rtl/student_tlul_mem.sv | 139 +++++++++++++
 tb/tb_student_tlul_mem.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/student_tlul_mem_pkg.sv
// Response metadata carried through the memory's request pipeline and response queue.
package student_tlul_mem_pkg;

  typedef struct packed {
    logic                           is_read;
    logic                           error;
    logic [tlul_pkg::TL_SZW-1:0]    size;
    logic [tlul_pkg::TL_AIW-1:0]    source;
    logic [tlul_pkg::TL_DW-1:0]     data;
  } rsp_meta_t;

  localparam logic [tlul_pkg::TL_DW-1:0] ErrResp = '0;

  // Only successful reads carry memory data; writes and errors return zero.
  function automatic rsp_meta_t attach_data(input rsp_meta_t meta,
                                            input logic [tlul_pkg::TL_DW-1:0] rdata);
    rsp_meta_t r;
    r      = meta;
    r.data = (meta.is_read && !meta.error) ? rdata : ErrResp;
    return r;
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL channel types shared by hosts, the crossbar and device-side blocks.
package tlul_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_SZW = 2;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_DUW = 4;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic                a_valid;
    tl_a_op_e            a_opcode;
    logic [2:0]          a_param;
    logic [TL_SZW-1:0]   a_size;
    logic [TL_AIW-1:0]   a_source;
    logic [TL_AW-1:0]    a_address;
    logic [TL_DBW-1:0]   a_mask;
    logic [TL_DW-1:0]    a_data;
    logic                d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                d_valid;
    tl_d_op_e            d_opcode;
    logic [2:0]          d_param;
    logic [TL_SZW-1:0]   d_size;
    logic [TL_AIW-1:0]   d_source;
    logic [TL_DIW-1:0]   d_sink;
    logic [TL_DW-1:0]    d_data;
    logic [TL_DUW-1:0]   d_user;
    logic                d_error;
    logic                a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/prim_fifo_sync.sv
// Synchronous FIFO; with Pass set, an empty FIFO forwards the write side combinationally.
module prim_fifo_sync #(
  parameter int Width = 8,
  parameter int Depth = 2,
  parameter bit Pass  = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wvalid,
  input  logic [Width-1:0] wdata,
  output logic             rvalid,
  input  logic             rready,
  output logic [Width-1:0] rdata
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  logic [Width-1:0] store_mem [Depth];
  logic [PtrW-1:0]  wptr_reg, rptr_reg;
  logic [CntW-1:0]  count_reg, count_next;
  logic             empty, full, bypass, push, pop;

  assign empty  = (count_reg == '0);
  assign full   = (count_reg == FullCnt);
  // An entry consumed in the same cycle it arrives never touches storage.
  assign bypass = Pass && empty && wvalid && rready;
  assign push   = wvalid && !full && !bypass;
  assign pop    = !empty && rready;
  assign rvalid = !empty || (Pass && wvalid);
  assign rdata  = empty ? wdata : store_mem[rptr_reg];

  always_comb begin
    count_next = count_reg + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (push) store_mem[wptr_reg] <= wdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) wptr_reg <= (wptr_reg == LastPtr) ? '0 : wptr_reg + 1'b1;
      if (pop)  rptr_reg <= (rptr_reg == LastPtr) ? '0 : rptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/student_tlul_mem.sv
// TL-UL device word memory: fixed-latency Get/Put with in-order responses and
// a small pass-through response queue that absorbs d_ready back-pressure.
module student_tlul_mem
  import tlul_pkg::*;
  import student_tlul_mem_pkg::*;
#(
  parameter int Depth   = 1024,
  parameter int Latency = 1
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_i,
  output tl_d2h_t tl_o
);

  localparam int IdxW  = $clog2(Depth);
  localparam int OutW  = $clog2(2 * Latency + 2);
  localparam int MetaW = $bits(rsp_meta_t);
  localparam logic [IdxW:0]   DepthL = (IdxW + 1)'(Depth);
  localparam logic [OutW-1:0] OutMax = OutW'(Latency + 1);

  logic [IdxW-1:0]  idx;
  logic             req_err, a_ready, accept, mem_we, mem_re, d_valid, d_pop;
  logic [TL_DW-1:0] mem_rdata;
  logic [OutW-1:0]  outstanding_reg, outstanding_next;
  rsp_meta_t        req_meta, last_meta, head;
  rsp_meta_t        stage_reg [Latency];
  logic             stage_valid_reg [Latency];
  logic [MetaW-1:0] fifo_rdata;
  logic             unused_param;

  assign unused_param = ^tl_i.a_param;
  assign idx = tl_i.a_address[2 +: IdxW];

  always_comb begin
    req_err = 1'b0;
    if (!(tl_i.a_opcode inside {Get, PutFullData, PutPartialData})) req_err = 1'b1;
    if (tl_i.a_size != 2'd2) req_err = 1'b1;
    if (tl_i.a_address[1:0] != 2'b00) req_err = 1'b1;
    if ({1'b0, idx} >= DepthL) req_err = 1'b1;
    if (tl_i.a_address[TL_AW-1:IdxW+2] != '0) req_err = 1'b1;
    if (tl_i.a_opcode == PutFullData && tl_i.a_mask != 4'hF) req_err = 1'b1;
  end

  // Ready depends only on the counter, so the pipeline plus queue can never overflow.
  assign a_ready = (outstanding_reg < OutMax);
  assign accept  = tl_i.a_valid && a_ready;
  assign mem_we  = accept && !req_err && (tl_i.a_opcode != Get);
  assign mem_re  = accept && !req_err && (tl_i.a_opcode == Get);

  for (genvar gi = 0; gi < TL_DBW; gi++) begin : g_bank
    logic [7:0] bank_mem [Depth];
    logic [7:0] rdata_reg;

    always_ff @(posedge clk_i) begin
      if (mem_we && tl_i.a_mask[gi]) bank_mem[idx] <= tl_i.a_data[8*gi +: 8];
      if (mem_re) rdata_reg <= bank_mem[idx];
    end

    assign mem_rdata[8*gi +: 8] = rdata_reg;
  end

  always_comb begin
    req_meta         = '0;
    req_meta.is_read = (tl_i.a_opcode == Get);
    req_meta.error   = req_err;
    req_meta.size    = tl_i.a_size;
    req_meta.source  = tl_i.a_source;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_valid_reg[0] <= 1'b0;
      stage_reg[0]       <= '0;
    end else begin
      stage_valid_reg[0] <= accept;
      if (accept) stage_reg[0] <= req_meta;
    end
  end

  // Read data joins the metadata as it leaves stage 0, where the block-RAM output lands.
  for (genvar gi = 1; gi < Latency; gi++) begin : g_stage
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        stage_valid_reg[gi] <= 1'b0;
        stage_reg[gi]       <= '0;
      end else begin
        stage_valid_reg[gi] <= stage_valid_reg[gi-1];
        stage_reg[gi]       <= (gi == 1) ? attach_data(stage_reg[0], mem_rdata)
                                         : stage_reg[gi-1];
      end
    end
  end

  assign last_meta = (Latency == 1) ? attach_data(stage_reg[0], mem_rdata)
                                    : stage_reg[Latency-1];

  prim_fifo_sync #(
    .Width (MetaW),
    .Depth (Latency + 1),
    .Pass  (1'b1)
  ) u_rsp_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .wvalid (stage_valid_reg[Latency-1]),
    .wdata  (last_meta),
    .rvalid (d_valid),
    .rready (tl_i.d_ready),
    .rdata  (fifo_rdata)
  );

  assign head  = rsp_meta_t'(fifo_rdata);
  assign d_pop = d_valid && tl_i.d_ready;

  always_comb begin
    outstanding_next = outstanding_reg;
    if (accept && !d_pop) outstanding_next = outstanding_reg + 1'b1;
    else if (!accept && d_pop) outstanding_next = outstanding_reg - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) outstanding_reg <= '0;
    else         outstanding_reg <= outstanding_next;
  end

  always_comb begin
    tl_o         = '0;
    tl_o.a_ready = a_ready;
    if (d_valid) begin
      tl_o.d_valid  = 1'b1;
      tl_o.d_opcode = head.is_read ? AccessAckData : AccessAck;
      tl_o.d_size   = head.size;
      tl_o.d_source = head.source;
      tl_o.d_data   = head.data;
      tl_o.d_error  = head.error;
    end
  end

endmodule

// File: tb/tb_student_tlul_mem.sv
// Directed bench for student_tlul_mem with a response scoreboard and a word-level memory model.
module tb_student_tlul_mem;
  import tlul_pkg::*;

  localparam int Depth   = 1024;
  localparam int Latency = 1;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  tl_h2d_t tl_i;
  tl_d2h_t tl_o;

  always #5 clk = ~clk;

  student_tlul_mem #(.Depth(Depth), .Latency(Latency)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .tl_i   (tl_i),
    .tl_o   (tl_o)
  );

  typedef struct {
    tl_d_op_e    op;
    logic        err;
    logic [1:0]  size;
    logic [7:0]  src;
    logic [31:0] data;
    bit          chk_data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] model [int];
  int vectors = 0, miscompares = 0, rsp_count = 0, last_wait = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack_d(tl_d_op_e op, logic [2:0] param, logic [1:0] size,
                                         logic [7:0] src, logic sink, logic [31:0] data,
                                         logic [3:0] user, logic err);
    return {10'b0, op, param, size, src, sink, data, user, err};
  endfunction

  function automatic bit req_err(tl_a_op_e op, logic [31:0] addr, logic [3:0] mask, logic [1:0] size);
    bit bad_op;
    bad_op = !(op == Get || op == PutFullData || op == PutPartialData);
    return bad_op || size != 2'd2 || addr[1:0] != 2'b00 || addr >= 32'(Depth * 4) ||
           (op == PutFullData && mask != 4'hF);
  endfunction

  // Called at the acceptance edge: update the model and queue the expected response.
  task automatic record();
    exp_t        e;
    bit          err;
    int          w;
    logic [31:0] cur;
    err        = req_err(tl_i.a_opcode, tl_i.a_address, tl_i.a_mask, tl_i.a_size);
    w          = int'(tl_i.a_address[31:2]);
    e.op       = (tl_i.a_opcode == Get) ? AccessAckData : AccessAck;
    e.err      = err;
    e.size     = tl_i.a_size;
    e.src      = tl_i.a_source;
    e.data     = 32'h0;
    e.chk_data = 1'b1;
    if (!err) begin
      if (tl_i.a_opcode == Get) begin
        if (model.exists(w)) e.data = model[w];
        else e.chk_data = 1'b0;
      end else begin
        cur = model.exists(w) ? model[w] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (tl_i.a_mask[b]) cur[8*b +: 8] = tl_i.a_data[8*b +: 8];
        model[w] = cur;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic present(input tl_a_op_e op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] mask, input logic [7:0] src, input logic [1:0] size);
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = op;
    tl_i.a_param   = 3'h0;
    tl_i.a_size    = size;
    tl_i.a_source  = src;
    tl_i.a_address = addr;
    tl_i.a_mask    = mask;
    tl_i.a_data    = data;
  endtask

  task automatic clock_step(output bit acc);
    @(negedge clk);
    acc = tl_i.a_valid && tl_o.a_ready;
    @(posedge clk);
    if (acc) record();
    #1;
  endtask

  task automatic send(input tl_a_op_e op, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] mask, input logic [7:0] src, input logic [1:0] size);
    bit acc;
    int waited;
    waited = 0;
    present(op, addr, data, mask, src, size);
    do begin
      clock_step(acc);
      waited++;
    end while (!acc && waited < 50);
    check("accepted", 64'(acc), 64'd1);
    last_wait    = waited;
    tl_i.a_valid = 1'b0;
  endtask

  // Scoreboard: every presented response is compared with the queue head; popped when taken.
  always @(negedge clk) begin
    if (rst_n && tl_o.d_valid) begin
      check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q[0];
        check(tl_i.d_ready ? "rsp" : "rsp_held",
              pack_d(tl_o.d_opcode, tl_o.d_param, tl_o.d_size, tl_o.d_source, tl_o.d_sink[0],
                     mon_e.chk_data ? tl_o.d_data : 32'h0, tl_o.d_user, tl_o.d_error),
              pack_d(mon_e.op, 3'h0, mon_e.size, mon_e.src, 1'b0,
                     mon_e.chk_data ? mon_e.data : 32'h0, 4'h0, mon_e.err));
        if (tl_i.d_ready) begin
          void'(exp_q.pop_front());
          rsp_count++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int nacc, k, base;
    tl_i         = '0;
    tl_i.d_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_d_fields",
          pack_d(tl_o.d_opcode, tl_o.d_param, tl_o.d_size, tl_o.d_source, tl_o.d_sink[0],
                 tl_o.d_data, tl_o.d_user, tl_o.d_error) | (64'(tl_o.d_valid) << 60), 64'd0);
    rst_n = 1'b1;
    #1;
    check("a_ready_after_rst", 64'(tl_o.a_ready), 64'd1);
    @(posedge clk);
    #1;

    // Put then Get on the following cycle
    send(PutFullData, 32'h10, 32'hDEAD_BEEF, 4'hF, 8'h01, 2'd2);
    check("put_lat", 64'({tl_o.d_valid, tl_o.d_opcode}), 64'({1'b1, AccessAck}));
    send(Get, 32'h10, 32'h0, 4'h0, 8'h02, 2'd2);
    check("get_lat", 64'({tl_o.d_valid, tl_o.d_opcode, tl_o.d_data}),
          64'({1'b1, AccessAckData, 32'hDEAD_BEEF}));

    // Partial write
    send(PutFullData, 32'h20, 32'hFFFF_FFFF, 4'hF, 8'h03, 2'd2);
    send(PutPartialData, 32'h20, 32'h1122_3344, 4'b0101, 8'h04, 2'd2);
    send(Get, 32'h20, 32'h0, 4'h0, 8'h05, 2'd2);
    check("partial_get", 64'({tl_o.d_valid, tl_o.d_data}), 64'({1'b1, 32'hFF22_FF44}));

    // Back-to-back stream
    for (int i = 0; i < 16; i++) begin
      send(PutFullData, 32'h100 + 32'(4 * i), $urandom, 4'hF, 8'(8'h10 + i), 2'd2);
      check("stream_wr_nobubble", 64'({32'(last_wait), tl_o.d_valid}), 64'({32'd1, 1'b1}));
    end
    for (int i = 0; i < 16; i++) begin
      send(Get, 32'h100 + 32'(4 * i), 32'h0, 4'h0, 8'(8'h20 + i), 2'd2);
      check("stream_rd_nobubble", 64'({32'(last_wait), tl_o.d_valid}), 64'({32'd1, 1'b1}));
    end
    repeat (3) @(posedge clk);
    #1;

    // Back-pressure with a_valid held
    tl_i.d_ready = 1'b0;
    nacc = 0;
    k    = 0;
    present(Get, 32'h100, 32'h0, 4'h0, 8'h40, 2'd2);
    for (int c = 0; c < 10; c++) begin
      clock_step(acc);
      if (acc) begin
        nacc++;
        k++;
        present(Get, 32'h100 + 32'(4 * k), 32'h0, 4'h0, 8'(8'h40 + k), 2'd2);
      end
    end
    check("stall_accepts", 64'(nacc), 64'(Latency + 1));
    check("stall_a_ready", 64'(tl_o.a_ready), 64'd0);
    check("stall_head", 64'({tl_o.d_valid, tl_o.d_source}), 64'({1'b1, 8'h40}));
    tl_i.a_valid = 1'b0;
    tl_i.d_ready = 1'b1;
    repeat (Latency + 4) @(posedge clk);
    #1;
    check("stall_drained", 64'(exp_q.size()), 64'd0);
    check("a_ready_after_drain", 64'(tl_o.a_ready), 64'd1);

    // Error requests
    send(PutFullData, 32'h0, 32'hA5A5_5A5A, 4'hF, 8'h30, 2'd2);
    send(PutFullData, 32'h30, 32'h1234_5678, 4'hF, 8'h31, 2'd2);
    send(Get, 32'(Depth * 4), 32'h0, 4'h0, 8'h50, 2'd2);
    check("err_get_oob", 64'({tl_o.d_valid, tl_o.d_error, tl_o.d_opcode, tl_o.d_data}),
          64'({1'b1, 1'b1, AccessAckData, 32'h0}));
    send(PutFullData, 32'h2, 32'hFFFF_FFFF, 4'hF, 8'h51, 2'd2);
    check("err_put_misaligned", 64'({tl_o.d_valid, tl_o.d_error, tl_o.d_opcode}),
          64'({1'b1, 1'b1, AccessAck}));
    send(PutFullData, 32'h30, 32'h0, 4'h7, 8'h52, 2'd2);
    check("err_put_mask", 64'({tl_o.d_valid, tl_o.d_error, tl_o.d_opcode}),
          64'({1'b1, 1'b1, AccessAck}));
    send(Get, 32'h0, 32'h0, 4'h0, 8'h53, 2'd1);
    check("err_get_size", 64'({tl_o.d_valid, tl_o.d_error}), 64'({1'b1, 1'b1}));
    send(tl_a_op_e'(3'h2), 32'h30, 32'h0, 4'hF, 8'h54, 2'd2);
    check("err_bad_opcode", 64'({tl_o.d_valid, tl_o.d_error}), 64'({1'b1, 1'b1}));
    send(PutFullData, 32'h8000_0030, 32'h0, 4'hF, 8'h55, 2'd2);
    check("err_upper_addr", 64'({tl_o.d_valid, tl_o.d_error}), 64'({1'b1, 1'b1}));
    send(Get, 32'h0, 32'h0, 4'h0, 8'h56, 2'd2);
    check("err_no_write_w0", 64'({tl_o.d_error, tl_o.d_data}), 64'({1'b0, 32'hA5A5_5A5A}));
    send(Get, 32'h30, 32'h0, 4'h0, 8'h57, 2'd2);
    check("err_no_write_w12", 64'({tl_o.d_error, tl_o.d_data}), 64'({1'b0, 32'h1234_5678}));
    repeat (3) @(posedge clk);
    #1;

    // Reset with responses outstanding
    tl_i.d_ready = 1'b0;
    present(Get, 32'h10, 32'h0, 4'h0, 8'h60, 2'd2);
    clock_step(acc);
    present(Get, 32'h20, 32'h0, 4'h0, 8'h61, 2'd2);
    clock_step(acc);
    present(Get, 32'h30, 32'h0, 4'h0, 8'h62, 2'd2);
    clock_step(acc);
    check("pre_rst_pending", 64'({tl_o.d_valid, tl_o.a_ready}), 64'({1'b1, 1'b0}));
    rst_n        = 1'b0;
    tl_i.a_valid = 1'b0;
    #1;
    check("rst_d_valid", 64'(tl_o.d_valid), 64'd0);
    exp_q.delete();
    model.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("a_ready_post_rst", 64'(tl_o.a_ready), 64'd1);
    @(posedge clk);
    #1;
    base         = rsp_count;
    tl_i.d_ready = 1'b1;
    send(Get, 32'h10, 32'h0, 4'h0, 8'h63, 2'd2);
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_rsp_count", 64'(rsp_count - base), 64'd1);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
